// File: rtl/dcache_pkg.sv
// rtl/dcache_pkg.sv - shared FSM state type and address-geometry helpers for dcache_nway
package dcache_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOOKUP,
        ST_WRITEBACK,
        ST_FILL_REQ,
        ST_FILL_WAIT
    } state_t;

    function automatic int ofs_size(input int line_size);
        return $clog2(line_size);
    endfunction

    function automatic int set_size(input int cache_size, input int line_size, input int num_ways);
        return $clog2(cache_size / (line_size * num_ways));
    endfunction

    function automatic int tag_size(input int xlen, input int cache_size, input int line_size,
                                    input int num_ways);
        return xlen - set_size(cache_size, line_size, num_ways) - ofs_size(line_size);
    endfunction

    // A single way still needs a one-bit way index.
    function automatic int way_bits(input int num_ways);
        return (num_ways > 1) ? $clog2(num_ways) : 1;
    endfunction

    function automatic int set_lsb(input int line_size);
        return ofs_size(line_size);
    endfunction

    function automatic int tag_lsb(input int cache_size, input int line_size, input int num_ways);
        return ofs_size(line_size) + set_size(cache_size, line_size, num_ways);
    endfunction

endpackage

// File: rtl/dcache_victim_sel.sv
// rtl/dcache_victim_sel.sv - picks the lowest invalid way, else the set's round-robin pointer
module dcache_victim_sel
    import dcache_pkg::*;
#(
    parameter int NUM_WAYS = 2
) (
    input  logic [NUM_WAYS-1:0]           valid,
    input  logic [way_bits(NUM_WAYS)-1:0] rr_ptr,
    output logic [way_bits(NUM_WAYS)-1:0] victim
);

    localparam int WAY_BITS = way_bits(NUM_WAYS);

    logic found;

    always_comb begin
        victim = rr_ptr;
        found  = 1'b0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (!valid[w] && !found) begin
                victim = WAY_BITS'(w);
                found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dcache_nway.sv
// rtl/dcache_nway.sv - N-way set-associative write-back write-allocate data cache
module dcache_nway
    import dcache_pkg::*;
#(
    parameter int LINE_SIZE  = 32,
    parameter int CACHE_SIZE = 1024,
    parameter int XLEN       = 32,
    parameter int NUM_WAYS   = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [XLEN-1:0]        req_addr,
    input  logic                   req_we,
    input  logic [XLEN-1:0]        req_wdata,
    input  logic [XLEN/8-1:0]      req_wstrb,
    output logic                   rsp_valid,
    output logic [XLEN-1:0]        rsp_rdata,
    output logic                   mem_req_valid,
    input  logic                   mem_req_ready,
    output logic                   mem_req_we,
    output logic [XLEN-1:0]        mem_req_addr,
    output logic [LINE_SIZE*8-1:0] mem_req_wdata,
    input  logic                   mem_rsp_valid,
    input  logic [LINE_SIZE*8-1:0] mem_rsp_rdata
);

    localparam int NUM_SETS  = CACHE_SIZE / (LINE_SIZE * NUM_WAYS);
    localparam int OFS_SIZE  = ofs_size(LINE_SIZE);
    localparam int SET_SIZE  = set_size(CACHE_SIZE, LINE_SIZE, NUM_WAYS);
    localparam int TAG_SIZE  = tag_size(XLEN, CACHE_SIZE, LINE_SIZE, NUM_WAYS);
    localparam int SET_LSB   = set_lsb(LINE_SIZE);
    localparam int TAG_LSB   = tag_lsb(CACHE_SIZE, LINE_SIZE, NUM_WAYS);
    localparam int WAY_BITS  = way_bits(NUM_WAYS);
    localparam int LINE_BITS = LINE_SIZE * 8;
    localparam int STRB      = XLEN / 8;
    localparam int WORD_LSB  = $clog2(STRB);
    localparam int WIDX_BITS = OFS_SIZE - WORD_LSB;

    state_t state, state_next;

    logic [TAG_SIZE-1:0]  lk_tag;
    logic [SET_SIZE-1:0]  lk_set;
    logic [WIDX_BITS-1:0] lk_widx;
    logic                 lk_we;
    logic [XLEN-1:0]      lk_wdata;
    logic [STRB-1:0]      lk_wstrb;
    logic [WAY_BITS-1:0]  victim_way;

    logic [TAG_SIZE-1:0]  tag_arr   [NUM_WAYS][NUM_SETS];
    logic [LINE_BITS-1:0] data_arr  [NUM_WAYS][NUM_SETS];
    logic [NUM_WAYS-1:0]  valid_arr [NUM_SETS];
    logic [NUM_WAYS-1:0]  dirty_arr [NUM_SETS];
    logic [WAY_BITS-1:0]  rr_arr    [NUM_SETS];

    logic                 hit;
    logic [WAY_BITS-1:0]  hit_way;
    logic [WAY_BITS-1:0]  victim_pick;
    logic [WAY_BITS-1:0]  rr_next;
    logic [LINE_BITS-1:0] hit_line;
    logic [LINE_BITS-1:0] merged_line;
    logic [XLEN-1:0]      hit_word;
    logic [XLEN-1:0]      merged_word;
    logic                 fill_done;

    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (valid_arr[lk_set][w] && (tag_arr[w][lk_set] == lk_tag)) begin
                hit     = 1'b1;
                hit_way = WAY_BITS'(w);
            end
        end
    end

    // Byte-merge a store into the addressed word of the hit line.
    always_comb begin
        hit_line = data_arr[hit_way][lk_set];
        hit_word = hit_line[lk_widx*XLEN +: XLEN];
        for (int b = 0; b < STRB; b++) begin
            merged_word[b*8 +: 8] = lk_wstrb[b] ? lk_wdata[b*8 +: 8] : hit_word[b*8 +: 8];
        end
        merged_line = hit_line;
        merged_line[lk_widx*XLEN +: XLEN] = merged_word;
    end

    assign rr_next   = (NUM_WAYS > 1) ? hit_way + WAY_BITS'(1) : '0;
    assign fill_done = (state == ST_FILL_WAIT) && mem_rsp_valid;

    dcache_victim_sel #(
        .NUM_WAYS (NUM_WAYS)
    ) u_victim_sel (
        .valid  (valid_arr[lk_set]),
        .rr_ptr (rr_arr[lk_set]),
        .victim (victim_pick)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next    = state;
        req_ready     = 1'b0;
        rsp_valid     = 1'b0;
        rsp_rdata     = '0;
        mem_req_valid = 1'b0;
        mem_req_we    = 1'b0;
        mem_req_addr  = '0;
        mem_req_wdata = '0;
        case (state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_next = ST_LOOKUP;
            end
            ST_LOOKUP: begin
                if (hit) begin
                    rsp_valid  = 1'b1;
                    rsp_rdata  = lk_we ? '0 : hit_word;
                    state_next = ST_IDLE;
                end else if (valid_arr[lk_set][victim_pick] && dirty_arr[lk_set][victim_pick]) begin
                    state_next = ST_WRITEBACK;
                end else begin
                    state_next = ST_FILL_REQ;
                end
            end
            ST_WRITEBACK: begin
                mem_req_valid = 1'b1;
                mem_req_we    = 1'b1;
                mem_req_addr  = {tag_arr[victim_way][lk_set], lk_set, {OFS_SIZE{1'b0}}};
                mem_req_wdata = data_arr[victim_way][lk_set];
                if (mem_req_ready) state_next = ST_FILL_REQ;
            end
            ST_FILL_REQ: begin
                mem_req_valid = 1'b1;
                mem_req_addr  = {lk_tag, lk_set, {OFS_SIZE{1'b0}}};
                if (mem_req_ready) state_next = ST_FILL_WAIT;
            end
            ST_FILL_WAIT: begin
                if (mem_rsp_valid) state_next = ST_LOOKUP;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (state == ST_IDLE && req_valid) begin
            lk_tag   <= req_addr[TAG_LSB +: TAG_SIZE];
            lk_set   <= req_addr[SET_LSB +: SET_SIZE];
            lk_widx  <= req_addr[WORD_LSB +: WIDX_BITS];
            lk_we    <= req_we;
            lk_wdata <= req_wdata;
            lk_wstrb <= req_wstrb;
        end
        if (state == ST_LOOKUP && !hit) begin
            victim_way <= victim_pick;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s < NUM_SETS; s++) begin
                valid_arr[s] <= '0;
                dirty_arr[s] <= '0;
                rr_arr[s]    <= '0;
            end
        end else if (state == ST_LOOKUP && hit) begin
            rr_arr[lk_set] <= rr_next;
            if (lk_we) dirty_arr[lk_set][hit_way] <= 1'b1;
        end else if (fill_done) begin
            valid_arr[lk_set][victim_way] <= 1'b1;
            dirty_arr[lk_set][victim_way] <= 1'b0;
        end
    end

    // Tag and data contents are meaningless until valid is set, so they carry no reset.
    always_ff @(posedge clk) begin
        if (state == ST_LOOKUP && hit && lk_we) begin
            data_arr[hit_way][lk_set] <= merged_line;
        end else if (fill_done) begin
            data_arr[victim_way][lk_set] <= mem_rsp_rdata;
            tag_arr[victim_way][lk_set]  <= lk_tag;
        end
    end

endmodule
